// File: rtl/irq_trap_ctrl_if.sv
// CSR access port of the machine-mode trap controller.
// The core side drives the strobe, address and data; the controller returns read data.
interface irq_trap_ctrl_if;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap controller feeding the decode stage trap inputs.
// Define IRQ_VECTORED_EN to enable vectored handler dispatch when mtvec[0] is set.
module irq_trap_ctrl #(
    parameter int          N_IRQ       = 4,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [N_IRQ-1:0] i_IRQ_SRC,
    input  logic             i_EN,
    input  logic [31:0]      i_PC,
    input  logic             i_MODE,
    irq_trap_ctrl_if.slave   csr,
    output logic             o_IRQ,
    output logic [31:0]      o_MEPC,
    output logic [31:0]      o_HANDLER_BASE,
    output logic [31:0]      o_MCAUSE
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ENTER,
        HANDLER
    } state_t;

    state_t           state;
    logic             irq_q;
    logic [N_IRQ-1:0] src_q;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mie_q;
    logic             st_mie;
    logic             st_mpie;
    logic [31:0]      mtvec_q;
    logic [31:0]      mepc_q;
    logic [31:0]      mcause_q;
    logic [3:0]       sel_idx;

    logic [N_IRQ-1:0] edge_set;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] sel_oh;
    logic [3:0]       win_idx;
    logic             sel_live;
    logic             accept;

    logic hit_mstatus, hit_mie, hit_mtvec;
    logic hit_mepc, hit_mcause, hit_mip;

    assign edge_set = i_IRQ_SRC & ~src_q;
    assign elig     = pending & mie_q & {N_IRQ{st_mie}};
    assign accept   = (state == REQ) && i_EN;

    always_comb begin
        win_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) win_idx = 4'(i);
        end
    end

    // One-hot of the latched winner, used for withdraw and claim.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            sel_oh[i] = (sel_idx == 4'(i));
        end
    end

    assign sel_live = |(elig & sel_oh);

    assign hit_mstatus = (csr.addr == A_MSTATUS);
    assign hit_mie     = (csr.addr == A_MIE);
    assign hit_mtvec   = (csr.addr == A_MTVEC);
    assign hit_mepc    = (csr.addr == A_MEPC);
    assign hit_mcause  = (csr.addr == A_MCAUSE);
    assign hit_mip     = (csr.addr == A_MIP);

    always_comb begin
        csr.rdata = '0;
        unique case (1'b1)
            hit_mstatus: csr.rdata = {24'd0, st_mpie, 3'd0, st_mie, 3'd0};
            hit_mie:     csr.rdata = {{(32-N_IRQ){1'b0}}, mie_q};
            hit_mtvec:   csr.rdata = mtvec_q;
            hit_mepc:    csr.rdata = mepc_q;
            hit_mcause:  csr.rdata = mcause_q;
            hit_mip:     csr.rdata = {{(32-N_IRQ){1'b0}}, pending};
            default:     csr.rdata = '0;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state    <= IDLE;
            irq_q    <= 1'b0;
            src_q    <= '0;
            pending  <= '0;
            mie_q    <= '0;
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
`ifdef IRQ_VECTORED_EN
            mtvec_q  <= RESET_MTVEC;
`else
            mtvec_q  <= {RESET_MTVEC[31:2], 2'b00};
`endif
            mepc_q   <= '0;
            mcause_q <= '0;
            sel_idx  <= '0;
        end else begin
            src_q   <= i_IRQ_SRC;
            // A new edge on the claimed line wins over its clear.
            pending <= (pending & ~(accept ? sel_oh : '0)) | edge_set;

            if (csr.we && hit_mie) mie_q <= csr.wdata[N_IRQ-1:0];
            if (csr.we && hit_mtvec) begin
`ifdef IRQ_VECTORED_EN
                mtvec_q <= csr.wdata;
`else
                mtvec_q <= {csr.wdata[31:2], 2'b00};
`endif
            end
            if (csr.we && hit_mstatus) begin
                st_mie  <= csr.wdata[3];
                st_mpie <= csr.wdata[7];
            end
            if (csr.we && hit_mepc) mepc_q <= {csr.wdata[31:2], 2'b00};
            if (csr.we && hit_mcause) mcause_q <= csr.wdata;

            // Trap entry/return updates land last so they override CSR writes.
            case (state)
                IDLE: begin
                    if (|elig && !i_MODE) begin
                        state   <= REQ;
                        irq_q   <= 1'b1;
                        sel_idx <= win_idx;
                    end
                end
                REQ: begin
                    if (i_EN) begin
                        mepc_q   <= i_PC & 32'hFFFF_FFFC;
                        mcause_q <= {1'b1, 26'd0, 1'b1, sel_idx};
                        st_mpie  <= st_mie;
                        st_mie   <= 1'b0;
                        state    <= ENTER;
                        irq_q    <= 1'b0;
                    end else if (!sel_live) begin
                        state <= IDLE;
                        irq_q <= 1'b0;
                    end
                end
                ENTER: begin
                    if (i_MODE) state <= HANDLER;
                end
                HANDLER: begin
                    if (!i_MODE) begin
                        st_mie  <= st_mpie;
                        st_mpie <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_IRQ    = irq_q;
    assign o_MEPC   = mepc_q;
    assign o_MCAUSE = mcause_q;

`ifdef IRQ_VECTORED_EN
    logic [31:0] vec_off;
    assign vec_off = {25'd0, 1'b1, sel_idx, 2'b00};
    assign o_HANDLER_BASE = mtvec_q[0]
        ? ({mtvec_q[31:2], 2'b00} + vec_off)
        : {mtvec_q[31:2], 2'b00};
`else
    assign o_HANDLER_BASE = {mtvec_q[31:2], 2'b00};
`endif

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Scoreboard bench for irq_trap_ctrl: expected trap records are queued at stimulus
// time and compared when decode accepts the trap.
module tb_irq_trap_ctrl;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src;
    logic        en;
    logic [31:0] pc;
    logic        mode;
    logic        irq;
    logic [31:0] mepc, hbase, mcause;

    irq_trap_ctrl_if csr_bus ();

    irq_trap_ctrl #(.N_IRQ(4), .RESET_MTVEC(32'h0000_0100)) dut (
        .i_CLK          (clk),
        .i_RST          (rst),
        .i_IRQ_SRC      (src),
        .i_EN           (en),
        .i_PC           (pc),
        .i_MODE         (mode),
        .csr            (csr_bus),
        .o_IRQ          (irq),
        .o_MEPC         (mepc),
        .o_HANDLER_BASE (hbase),
        .o_MCAUSE       (mcause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] epc;
        logic [31:0] cause;
        logic [31:0] hb;
    } exp_t;

    exp_t sb[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_taken = 0;
    int   irq_hi  = 0;
    logic took    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Accept edge is the posedge after a negedge with o_IRQ & i_EN.
    always @(negedge clk) begin
        if (took) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("trap_mepc", mepc, e.epc);
                chk("trap_mcause", mcause, e.cause);
                chk("trap_hbase", hbase, e.hb);
            end
            n_taken++;
        end
        if (irq) irq_hi++;
        took = irq && en && !rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_bus.we    = 1'b1;
        csr_bus.addr  = a;
        csr_bus.wdata = d;
        tick();
        csr_bus.we    = 1'b0;
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] a,
                           input logic [31:0] exp);
        csr_bus.addr = a;
        #1;
        chk(tag, csr_bus.rdata, exp);
    endtask

    task automatic pulse(input logic [3:0] v);
        src = v;
        tick();
        src = 4'd0;
    endtask

    task automatic wait_trap();
        int start = n_taken;
        int k = 0;
        while (n_taken == start && k < 20) begin
            tick();
            k++;
        end
        chk("trap_timeout", 32'(n_taken != start), 32'd1);
    endtask

    task automatic mret();
        mode = 1'b1;
        tick();
        mode = 1'b0;
        tick();
    endtask

    function automatic exp_t mk(input logic [31:0] p, input int idx,
                                input logic [31:0] hb);
        exp_t e;
        e.epc   = p;
        e.cause = 32'h8000_0010 + 32'(idx);
        e.hb    = hb;
        return e;
    endfunction

    logic [31:0] vec_mtvec, vec_hb3, vec_hb0;

    initial begin
`ifdef IRQ_VECTORED_EN
        vec_mtvec = 32'h201;
        vec_hb3   = 32'h24C;
        vec_hb0   = 32'h240;
`else
        vec_mtvec = 32'h200;
        vec_hb3   = 32'h200;
        vec_hb0   = 32'h200;
`endif
        rst = 1'b1; src = '0; en = 1'b1; pc = '0; mode = 1'b0;
        csr_bus.we = 1'b0; csr_bus.addr = '0; csr_bus.wdata = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_mepc", mepc, 32'd0);
        chk("rst_mcause", mcause, 32'd0);
        chk("rst_hbase", hbase, 32'h100);
        chk_csr("rst_mtvec", A_MTVEC, 32'h100);
        chk_csr("rst_mstatus", A_MSTATUS, 32'd0);
        chk_csr("rst_mip", A_MIP, 32'd0);
        chk_csr("unmapped", 12'h7C0, 32'd0);

        // Basic trap
        csr_wr(A_MSTATUS, 32'h8);
        csr_wr(A_MIE, 32'h1);
        pc = 32'h40;
        sb.push_back(mk(32'h40, 0, 32'h100));
        irq_hi = 0;
        pulse(4'b0001);
        wait_trap();
        chk("basic_irq_low", 32'(irq), 32'd0);
        chk("basic_irq_width", 32'(irq_hi), 32'd1);
        chk_csr("basic_mstatus", A_MSTATUS, 32'h80);
        chk_csr("basic_mip", A_MIP, 32'd0);
        mret();
        chk_csr("basic_mret", A_MSTATUS, 32'h88);

        // Priority
        csr_wr(A_MIE, 32'hF);
        pc = 32'h100;
        sb.push_back(mk(32'h100, 1, 32'h100));
        sb.push_back(mk(32'h104, 2, 32'h100));
        pulse(4'b0110);
        wait_trap();
        chk_csr("prio_mip", A_MIP, 32'h4);
        pc = 32'h104;
        mret();
        wait_trap();
        mret();

        // Stall
        en = 1'b0;
        irq_hi = 0;
        pulse(4'b0001);
        tick();
        chk("stall_rise", 32'(irq), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", 32'(irq), 32'd1);
        end
        en = 1'b1;
        pc = 32'h88;
        sb.push_back(mk(32'h88, 0, 32'h100));
        wait_trap();
        chk("stall_width", 32'(irq_hi), 32'd4);
        chk("stall_mepc", mepc, 32'h88);
        mret();

        // Withdraw
        en = 1'b0;
        pulse(4'b1000);
        tick();
        chk("wd_rise", 32'(irq), 32'd1);
        csr_wr(A_MSTATUS, 32'h0);
        tick();
        chk("wd_fall", 32'(irq), 32'd0);
        chk_csr("wd_pending", A_MIP, 32'h8);

        // Gating in machine mode, then MRET restore
        mode = 1'b1;
        csr_wr(A_MSTATUS, 32'h8);
        pulse(4'b0010);
        repeat (3) tick();
        chk("gate_irq", 32'(irq), 32'd0);
        chk_csr("gate_mip", A_MIP, 32'hA);
        en = 1'b1;
        pc = 32'h200;
        sb.push_back(mk(32'h200, 1, 32'h100));
        sb.push_back(mk(32'h200, 3, 32'h100));
        mode = 1'b0;
        wait_trap();
        chk_csr("gate_mip2", A_MIP, 32'h8);
        mret();
        chk_csr("mret_mie", A_MSTATUS, 32'h88);
        wait_trap();
        mret();

        // Vectored / direct handler base
        csr_wr(A_MTVEC, 32'h201);
        chk_csr("vec_mtvec", A_MTVEC, vec_mtvec);
        pc = 32'h300;
        sb.push_back(mk(32'h300, 3, vec_hb3));
        pulse(4'b1000);
        wait_trap();
        chk("vec_hbase", hbase, vec_hb3);
        mret();

        // Reset in HANDLER
        pc = 32'h44;
        sb.push_back(mk(32'h44, 0, vec_hb0));
        pulse(4'b0001);
        wait_trap();
        mode = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_irq", 32'(irq), 32'd0);
        chk("mrst_mepc", mepc, 32'd0);
        chk("mrst_mcause", mcause, 32'd0);
        chk_csr("mrst_mtvec", A_MTVEC, 32'h100);
        chk_csr("mrst_mstatus", A_MSTATUS, 32'd0);
        rst = 1'b0;
        mode = 1'b0;
        csr_wr(A_MSTATUS, 32'h8);
        csr_wr(A_MIE, 32'h1);
        pc = 32'h48;
        sb.push_back(mk(32'h48, 0, 32'h100));
        pulse(4'b0001);
        wait_trap();
        chk_csr("post_mstatus", A_MSTATUS, 32'h80);

        tick();
        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
